// File: rtl/buffer_stream_ctrl.sv
// Buffer stream controller: arbitrates the per-PE bank buffer between the host
// word port (mode 0) and a streaming tile pass (mode 1). A pass issues len
// broadcast reads from rd_base, follows each one through the bank + PE-array
// latency in a valid pipe, and issues the matching write at wr_base.
module buffer_stream_ctrl #(
    parameter int ADDR_RAM = 10,
    parameter int PE_LAT   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_RAM-1:0] rd_base,
    input  logic [ADDR_RAM-1:0] wr_base,
    input  logic [ADDR_RAM:0]   len,
    input  logic                pe_ready,
    input  logic                host_req,
    output logic                host_gnt,
    output logic                mode,
    output logic                m1_r_en,
    output logic [ADDR_RAM-1:0] m1_r_addr,
    output logic                m1_w_en,
    output logic [ADDR_RAM-1:0] m1_w_addr,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam logic [ADDR_RAM:0] ONE = {{ADDR_RAM{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_RAM-1:0] rd_base_q, rd_base_d;
    logic [ADDR_RAM-1:0] wr_base_q, wr_base_d;
    logic [ADDR_RAM:0]   len_q, len_d;
    logic [ADDR_RAM:0]   rcnt_q, rcnt_d;
    logic [ADDR_RAM:0]   wcnt_q, wcnt_d;
    // Bit i set: a read issued i+1 advancing cycles ago is in flight.
    logic [PE_LAT-1:0]   vld_pipe_q, vld_pipe_d;

    logic active;
    logic rd_fire;
    logic wr_fire;
    logic last_rd;
    logic last_wr;

    // Everything in the pass advances only on pe_ready; a stall freezes all.
    assign active  = (state_q == READ) || (state_q == DRAIN);
    assign rd_fire = (state_q == READ) && pe_ready;
    assign wr_fire = active && pe_ready && vld_pipe_q[PE_LAT-1];
    assign last_rd = rd_fire && (rcnt_q == len_q - ONE);
    assign last_wr = wr_fire && (wcnt_q == len_q - ONE);

    // Outputs are decoded from registered state; only the enables look at pe_ready.
    assign mode      = (state_q != IDLE);
    assign busy      = active;
    assign done      = (state_q == DONE);
    assign host_gnt  = (state_q == IDLE) && host_req && !start;
    assign m1_r_en   = rd_fire;
    assign m1_w_en   = wr_fire;
    assign m1_r_addr = rd_base_q + rcnt_q[ADDR_RAM-1:0];
    assign m1_w_addr = wr_base_q + wcnt_q[ADDR_RAM-1:0];

    // Next-state logic: capture on start, count reads/writes, sequence the pass.
    always_comb begin
        state_d    = state_q;
        rd_base_d  = rd_base_q;
        wr_base_d  = wr_base_q;
        len_d      = len_q;
        rcnt_d     = rcnt_q;
        wcnt_d     = wcnt_q;
        vld_pipe_d = vld_pipe_q;

        if (active && pe_ready) begin
            vld_pipe_d[0] = rd_fire;
            for (int i = 1; i < PE_LAT; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
        end
        if (rd_fire) rcnt_d = rcnt_q + ONE;
        if (wr_fire) wcnt_d = wcnt_q + ONE;

        case (state_q)
            IDLE: begin
                if (start) begin
                    rd_base_d  = rd_base;
                    wr_base_d  = wr_base;
                    len_d      = len;
                    rcnt_d     = '0;
                    wcnt_d     = '0;
                    vld_pipe_d = '0;
                    state_d    = (len == '0) ? DONE : READ;
                end
            end
            READ:    if (last_rd) state_d = DRAIN;
            // The last write always trails the last read, so it can only land here.
            DRAIN:   if (last_wr) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any pass in flight immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_base_q  <= '0;
            wr_base_q  <= '0;
            len_q      <= '0;
            rcnt_q     <= '0;
            wcnt_q     <= '0;
            vld_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_base_q  <= rd_base_d;
            wr_base_q  <= wr_base_d;
            len_q      <= len_d;
            rcnt_q     <= rcnt_d;
            wcnt_q     <= wcnt_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

endmodule

// File: tb/tb_buffer_stream_ctrl.sv
// Bench for buffer_stream_ctrl. Reference model: a pass with len>0 is a
// sequence of len+PE_LAT steps, one per pe_ready cycle; step s reads row s
// (s<len) and writes row s-PE_LAT (s>=PE_LAT). The cycle after the last step
// is the done cycle, then the block is idle again.
module tb_buffer_stream_ctrl;
    localparam int AW  = 10;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] rd_base = '0;
    logic [AW-1:0] wr_base = '0;
    logic [AW:0]   len = '0;
    logic          pe_ready = 1'b0;
    logic          host_req = 1'b0;
    logic          host_gnt, mode, m1_r_en, m1_w_en, busy, done;
    logic [AW-1:0] m1_r_addr, m1_w_addr;

    int checks = 0;
    int failures = 0;

    buffer_stream_ctrl #(.ADDR_RAM(AW), .PE_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .rd_base(rd_base), .wr_base(wr_base),
        .len(len), .pe_ready(pe_ready), .host_req(host_req), .host_gnt(host_gnt),
        .mode(mode), .m1_r_en(m1_r_en), .m1_r_addr(m1_r_addr), .m1_w_en(m1_w_en),
        .m1_w_addr(m1_w_addr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Runs one pass and checks every cycle against the step model.
    // flags order: {host_gnt, mode, busy, done, m1_r_en, m1_w_en}
    task automatic run_pass(input logic [AW-1:0] rb, input logic [AW-1:0] wb,
                            input logic [AW:0] ln, input int stall_pct,
                            input logic [63:0] stall_mask, input bit spurious,
                            input bit host_hold, input string tag);
        int steps, s, cyc;
        logic rdy, exp_r, exp_w;
        logic [AW-1:0] ra, wa;
        logic [5:0] got, exp;
        steps = (ln == 0) ? 0 : int'(ln) + LAT;
        @(posedge clk); #1;
        start = 1'b1; rd_base = rb; wr_base = wb; len = ln;
        host_req = host_hold; pe_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        got = {host_gnt, mode, busy, done, m1_r_en, m1_w_en};
        checks++;
        if (got !== 6'b000000) begin
            failures++;
            $display("FAIL %s start_cycle flags got=%b exp=000000", tag, got);
        end
        s = 0; cyc = 0;
        while (s < steps) begin
            cyc++;
            @(posedge clk); #1;
            if (cyc < 64 && stall_mask[cyc]) rdy = 1'b0;
            else rdy = ($urandom_range(0, 99) >= stall_pct);
            pe_ready = rdy;
            start = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            if (spurious) begin
                rd_base = AW'($urandom); wr_base = AW'($urandom);
                len = (AW+1)'($urandom_range(0, 8));
            end
            host_req = host_hold ? 1'b1 : 1'($urandom_range(0, 1));
            exp_r = rdy && (s < int'(ln));
            exp_w = rdy && (s >= LAT);
            ra = rb + AW'(s);
            wa = wb + AW'(s - LAT);
            @(negedge clk);
            got = {host_gnt, mode, busy, done, m1_r_en, m1_w_en};
            exp = {1'b0, 1'b1, 1'b1, 1'b0, exp_r, exp_w};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL %s cyc%0d flags got=%b exp=%b", tag, cyc, got, exp);
            end
            if (exp_r) begin
                checks++;
                if (m1_r_addr !== ra) begin
                    failures++;
                    $display("FAIL %s cyc%0d r_addr got=%h exp=%h", tag, cyc, m1_r_addr, ra);
                end
            end
            if (exp_w) begin
                checks++;
                if (m1_w_addr !== wa) begin
                    failures++;
                    $display("FAIL %s cyc%0d w_addr got=%h exp=%h", tag, cyc, m1_w_addr, wa);
                end
            end
            if (rdy) s++;
        end
        // done cycle
        cyc++;
        @(posedge clk); #1;
        start = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
        host_req = 1'b1; pe_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        got = {host_gnt, mode, busy, done, m1_r_en, m1_w_en};
        checks++;
        if (got !== 6'b010100) begin
            failures++;
            $display("FAIL %s done_cyc%0d flags got=%b exp=010100", tag, cyc, got);
        end
        // back in idle, host held -> granted
        @(posedge clk); #1;
        start = 1'b0; host_req = 1'b1;
        @(negedge clk);
        got = {host_gnt, mode, busy, done, m1_r_en, m1_w_en};
        checks++;
        if (got !== 6'b100000) begin
            failures++;
            $display("FAIL %s idle_after flags got=%b exp=100000", tag, got);
        end
        @(posedge clk); #1;
        host_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [25:0] all;
        #1 rst = 1'b1;
        #2;
        all = {host_gnt, mode, busy, done, m1_r_en, m1_w_en, m1_r_addr, m1_w_addr};
        checks++;
        if (all !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", all);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0; host_req = 1'b1; start = 1'b0;
        @(negedge clk);
        checks++;
        if ({host_gnt, mode} !== 2'b10) begin
            failures++;
            $display("FAIL reset_host_gnt got=%b exp=10", {host_gnt, mode});
        end
        @(posedge clk); #1;
        host_req = 1'b0;
    endtask

    task automatic test_basic();
        run_pass(10'h010, 10'h200, 11'd4, 0, 64'h0, 1'b0, 1'b0, "basic");
    endtask

    task automatic test_stall();
        run_pass(10'h010, 10'h200, 11'd4, 0, 64'h0C, 1'b0, 1'b0, "stall");
    endtask

    task automatic test_wrap();
        run_pass(10'h3FE, 10'h3FF, 11'd4, 0, 64'h0, 1'b0, 1'b0, "wrap");
    endtask

    task automatic test_len_zero();
        run_pass(10'h123, 10'h321, 11'd0, 0, 64'h0, 1'b0, 1'b0, "len0");
    endtask

    task automatic test_host_restart();
        run_pass(10'h040, 10'h080, 11'd6, 20, 64'h0, 1'b1, 1'b1, "host_restart");
    endtask

    task automatic test_full_len();
        run_pass(10'h155, 10'h2AA, 11'd1024, 0, 64'h0, 1'b0, 1'b0, "full_len");
    endtask

    task automatic test_random();
        for (int p = 0; p < 20; p++) begin
            logic [AW:0] ln;
            ln = (p % 7 == 6) ? '0 : (AW+1)'($urandom_range(1, 20));
            run_pass(AW'($urandom), AW'($urandom), ln, 30, 64'h0, 1'b1,
                     1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_async_reset();
        logic [25:0] all;
        @(posedge clk); #1;
        start = 1'b1; rd_base = 10'h0A0; wr_base = 10'h0B0; len = 11'd8; pe_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, m1_r_en} !== 2'b11) begin
            failures++;
            $display("FAIL arst_pre busy_ren got=%b exp=11", {busy, m1_r_en});
        end
        #2 rst = 1'b1;
        #1;
        all = {host_gnt, mode, busy, done, m1_r_en, m1_w_en, m1_r_addr, m1_w_addr};
        checks++;
        if (all !== '0) begin
            failures++;
            $display("FAIL arst_outputs got=%h exp=0", all);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if ({mode, busy, done, m1_r_en, m1_w_en} !== 5'b0) begin
                failures++;
                $display("FAIL arst_after cyc%0d got=%b exp=00000", c,
                         {mode, busy, done, m1_r_en, m1_w_en});
            end
        end
        pe_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_len_zero();
        test_host_restart();
        test_random();
        test_full_len();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/buffer_stream_ctrl.md
Name: buffer_stream_ctrl

Overview:
- Sequencer for the per-PE memory bank buffer.
- Owns the buffer mode select and arbitrates between the host word port (mode 0) and a streaming tile pass (mode 1).
- In a tile pass it issues `len` broadcast reads starting at rd_base, tracks them through the fixed bank + PE-array latency, and issues matching broadcast writes starting at wr_base.
- Stalls on PE-array backpressure.

Parameters:
- ADDR_RAM, 10, bank address width.
- PE_LAT, 3, cycles from m1_r_en to the result word on m1_input_bus (bank read + PE pipeline); must be >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin tile pass; sampled only in IDLE
- rd_base  in  ADDR_RAM  first read row; captured on accepted start
- wr_base  in  ADDR_RAM  first write row; captured on accepted start
- len  in  ADDR_RAM+1  rows to process, 0..2^ADDR_RAM; captured on accepted start
- pe_ready  in  1  PE array can advance; 0 freezes the pass
- host_req  in  1  host wants buffer port (mode 0)
- host_gnt  out  1  host access granted this cycle
- mode  out  1  buffer mode: 0 = host, 1 = stream
- m1_r_en  out  1  broadcast read enable
- m1_r_addr  out  ADDR_RAM  read row
- m1_w_en  out  1  broadcast write enable
- m1_w_addr  out  ADDR_RAM  write row
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at pass end

Behaviour:
- Reset values: state IDLE, all counters and valid pipe cleared.
  - Outputs: mode=0, busy=0, done=0, m1_r_en=0, m1_w_en=0, addrs=0, host_gnt=0.
  - Async assertion mid-pass aborts the pass immediately: no further r_en/w_en, no done.
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - mode=0, host_gnt = host_req & ~start (combinational).
  - start=1 captures bases and len, zeroes rcnt and wcnt.
    - len=0: next state DONE.
    - Otherwise: next state READ.
  - Start beats host: same-cycle start and host_req gives host_gnt=0.
- READ:
  - busy=1, mode=1.
  - m1_r_en = pe_ready; m1_r_addr = rd_base + rcnt, mod 2^ADDR_RAM (wraps).
  - rcnt increments on each issued read.
  - When the last read issues (rcnt == len-1 with pe_ready), next state DRAIN.
- Valid pipe: PE_LAT-stage shift register of read-issued bits.
  - Shifts only when pe_ready=1.
  - pe_ready=0 freezes rcnt, wcnt and the pipe.
  - r_en and w_en are both 0 during a stall.
- Write side, in READ or DRAIN: m1_w_en = pipe_tail & pe_ready; m1_w_addr = wr_base + wcnt, mod 2^ADDR_RAM.
  - wcnt increments on each issued write.
- DRAIN:
  - No reads issued; writes continue.
  - When the write with wcnt == len-1 issues, next state DONE.
- DONE:
  - done=1 for exactly one cycle; busy=0, mode=1, no r_en/w_en.
  - Next state IDLE.
- Timing:
  - Start accepted at edge 0 gives first r_en in the cycle after edge 0.
  - With no stalls, write k occurs exactly PE_LAT cycles after read k.
  - Total pass length is len + PE_LAT cycles of busy, then the done cycle.
- host_gnt=0 whenever state != IDLE; host_req is never queued, so the host holds it.
- start while busy or in DONE is ignored.
- len = 2^ADDR_RAM is legal: every row is read once and addresses wrap.
- Overlapping rd and wr ranges are legal.
  - The controller issues r_en and w_en in the same cycle to different rows.
  - Same-row conflicts are the caller's responsibility.

Test Plan:
- Reset then host_req=1, start=0 -> host_gnt=1, mode=0.
  - Assert rst mid-cycle -> all outputs 0 asynchronously.
- start, rd_base=0x010, wr_base=0x200, len=4, PE_LAT=3, pe_ready=1:
  - r_en in cycles 1-4 at addrs 0x010-0x013.
  - w_en in cycles 4-7 at addrs 0x200-0x203.
  - done in cycle 8, then IDLE.
- Same pass, pe_ready=0 in cycles 2-3:
  - No r_en/w_en while stalled.
  - Remaining reads resume at 0x011.
  - Writes still pair 1:1 with reads; done in cycle 10.
- rd_base=0x3FE, len=4 -> reads 0x3FE, 0x3FF, 0x000, 0x001 (wrap); four writes issued.
- start with len=0 -> no r_en/w_en, done in cycle 1, busy never 1.
- start and host_req together in IDLE -> host_gnt=0, pass runs.
  - host_req held through pass -> host_gnt=1 the cycle after done.
  - A second start mid-pass is ignored: the bases from the first start are used throughout.
